// File: rtl/alu_muldiv_seq.sv
// Sequences 16x16 unsigned multiply and 16/16 unsigned divide over the shared ALU, one add per cycle.
// Latency 17 cycles start->done (1 cycle for divide-by-zero); start is ignored while busy.
module alu_muldiv_seq #(
   parameter logic [2:0] OP_ADD = 3'b100,
   parameter int         ITERS  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        op_div,
   input  logic [15:0] opa,
   input  logic [15:0] opb,
   output logic        busy,
   output logic        done,
   output logic [15:0] result_hi,
   output logic [15:0] result_lo,
   output logic        div_by_zero,
   output logic [15:0] alu_A,
   output logic [15:0] alu_B,
   output logic        alu_Cin,
   output logic [2:0]  alu_Op,
   output logic        alu_invA,
   output logic        alu_invB,
   output logic        alu_sign,
   input  logic [15:0] alu_Out,
   input  logic        alu_Ofl
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

   state_t      state;
   logic        is_div;
   logic [15:0] reg_hi;   // P_hi for multiply, partial remainder R for divide
   logic [15:0] reg_lo;   // P_lo (remaining multiplier bits) / quotient Q
   logic [15:0] reg_m;    // multiplicand M / divisor D
   logic [3:0]  cnt;

   logic [15:0] div_t;
   logic [16:0] s17;
   logic        ge;
   logic [15:0] nxt_hi;
   logic [15:0] nxt_lo;

   always_comb begin
      div_t = {reg_hi[14:0], reg_lo[15]};
      // R[15] set means the shifted remainder exceeds 16 bits, so it is always >= D
      ge    = alu_Ofl | reg_hi[15];
      s17   = reg_lo[0] ? {alu_Ofl, alu_Out} : {1'b0, reg_hi};
      if (is_div) begin
         nxt_hi = ge ? alu_Out : div_t;
         nxt_lo = {reg_lo[14:0], ge};
      end else begin
         nxt_hi = s17[16:1];
         nxt_lo = {s17[0], reg_lo[15:1]};
      end
   end

   always_comb begin
      alu_A    = 16'h0000;
      alu_B    = 16'h0000;
      alu_Cin  = 1'b0;
      alu_Op   = OP_ADD;
      alu_invA = 1'b0;
      alu_invB = 1'b0;
      alu_sign = 1'b0;
      if (state == S_ITER) begin
         alu_A    = is_div ? div_t : reg_hi;
         alu_B    = reg_m;
         alu_invB = is_div;
         alu_Cin  = is_div;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         is_div      <= 1'b0;
         reg_hi      <= 16'h0000;
         reg_lo      <= 16'h0000;
         reg_m       <= 16'h0000;
         cnt         <= 4'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         result_hi   <= 16'h0000;
         result_lo   <= 16'h0000;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  is_div      <= op_div;
                  reg_hi      <= 16'h0000;
                  reg_lo      <= op_div ? opa : opb;
                  reg_m       <= op_div ? opb : opa;
                  cnt         <= 4'd0;
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  if (op_div && (opb == 16'h0000)) begin
                     state       <= S_DONE;
                     done        <= 1'b1;
                     result_hi   <= opa;
                     result_lo   <= 16'hFFFF;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= S_ITER;
                  end
               end
            end
            S_ITER: begin
               reg_hi <= nxt_hi;
               reg_lo <= nxt_lo;
               cnt    <= cnt + 4'd1;
               if (cnt == 4'(ITERS - 1)) begin
                  state     <= S_DONE;
                  done      <= 1'b1;
                  result_hi <= nxt_hi;
                  result_lo <= nxt_lo;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that runs 16x16 unsigned multiply and 16/16 unsigned divide on the shared 16-bit ALU.
- Uses the ALU as an add/subtract engine only. The ALU's A, B, Cin, Op, invA, invB and sign are driven from this block; its Out and Ofl are fed back.
- Shift-and-add (multiply) and restoring division (divide), one ALU operation per cycle, start/busy/done handshake.
- Sits beside the execute stage and services MUL/DIV-class instructions.

Parameters:
- OP_ADD, 3'b100, ALU Op encoding for add. The only Op value this block ever drives.
- ITERS, 16, iterations per operation (equals the datapath width; not intended to be changed).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- op_div  input  1  0 = multiply, 1 = divide. Sampled with start.
- opa  input  16  multiplicand / dividend.
- opb  input  16  multiplier / divisor.
- busy  output  1  high in ITER and DONE.
- done  output  1  one-cycle pulse, results valid.
- result_hi  output  16  product[31:16] / remainder.
- result_lo  output  16  product[15:0] / quotient.
- div_by_zero  output  1  set with done when divide had opb = 0.
- alu_A  output  16  ALU A operand.
- alu_B  output  16  ALU B operand.
- alu_Cin  output  1  ALU carry-in.
- alu_Op  output  3  ALU operation select.
- alu_invA  output  1  ALU invert-A control.
- alu_invB  output  1  ALU invert-B control.
- alu_sign  output  1  ALU signed-mode control.
- alu_Out  input  16  ALU result.
- alu_Ofl  input  1  ALU carry out of bit 15 (alu_sign = 0).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Reset values:
  - State = IDLE.
  - busy, done, div_by_zero = 0.
  - result_hi, result_lo = 0.
  - Internal registers and iteration counter = 0.
- Reset mid-operation aborts immediately. No done pulse follows.
- ALU drive outside ITER (combinational from state):
  - alu_A = alu_B = 0, alu_Cin = 0, alu_invA = alu_invB = 0, alu_sign = 0, alu_Op = OP_ADD.
- ALU drive in ITER: alu_sign = 0 and alu_invA = 0 always; alu_Op = OP_ADD always.
- State IDLE:
  - start = 1 latches op_div, opa, opb and clears the counter.
  - If op_div = 1 and opb = 0, go to DONE with result_lo = 16'hFFFF, result_hi = opa, div_by_zero = 1.
  - Otherwise go to ITER.
- State ITER: exactly ITERS cycles, counter 0..15. Leaves for DONE after counter = 15.
- Multiply, per ITER cycle. Registers are P_hi = 0 and P_lo = opb at start; M = opa.
  - alu_A = P_hi, alu_B = M, alu_invB = 0, alu_Cin = 0.
  - If P_lo[0] = 1, s17 = {alu_Ofl, alu_Out}. Else s17 = {1'b0, P_hi}.
  - {P_hi, P_lo} <= {s17, P_lo[15:1]} (33-bit value shifted right by one).
  - Final result: result_hi = P_hi, result_lo = P_lo.
- Divide, per ITER cycle. Registers are R = 0 and Q = opa at start; D = opb.
  - t = {R[14:0], Q[15]}.
  - alu_A = t, alu_B = D, alu_invB = 1, alu_Cin = 1 (computes t - D).
  - ge = alu_Ofl | R[15].
  - R <= ge ? alu_Out : t.
  - Q <= {Q[14:0], ge}.
  - Final result: result_lo = Q, result_hi = R.
- State DONE: done = 1 for exactly one cycle, busy = 1, then IDLE.
- Latency: done is high in the 17th cycle after the cycle in which start is sampled. For divide-by-zero it is the 1st cycle after.
- Result hold: result_hi, result_lo and div_by_zero are stable from done until the next accepted start. div_by_zero clears on the next accepted start.
- start while busy = 1 (ITER or DONE) is ignored. There is no queueing; the operands in flight are unaffected by input changes.
- start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Sign: all arithmetic is unsigned. opa and opb are treated as 0..65535.

Test Plan:
- mul opa = 16'h0003, opb = 16'h0005 -> done at cycle 17; result_hi = 0, result_lo = 16'h000F.
- mul 16'hFFFF x 16'hFFFF -> result_hi = 16'hFFFE, result_lo = 16'h0001. Exercises the carry-out path.
- div 100 / 7 -> result_lo = 14, result_hi = 2, div_by_zero = 0. div 16'hFFFF / 16'h8001 -> result_lo = 1, result_hi = 16'h7FFE.
- div opa = 16'h1234, opb = 0 -> done 1 cycle after start; result_lo = 16'hFFFF, result_hi = 16'h1234, div_by_zero = 1.
- start pulsed with new operands at ITER counter = 5 -> ignored; the original result is returned and done pulses exactly once. In IDLE, the ALU outputs hold their idle values.
- rst asserted asynchronously mid-ITER -> busy, done and results = 0 immediately. A subsequent start runs a full, correct 17-cycle operation.
